// File: rtl/cov_toggle_collector.sv
// Toggle-coverage collector.
// Each channel arms on its first enabled sample, then counts one hit for every
// enabled cycle in which its sampled value differs from the previously seen
// value. Counters saturate. A single-cycle read port returns a counter value
// one cycle after the request, and a registered summary reports how many
// channels have reached the coverage threshold.
module cov_toggle_collector #(
  parameter int NUM_CH     = 8,
  parameter int SIG_W      = 8,
  parameter int CNT_W      = 16,
  parameter int HIT_THRESH = 1,
  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int COV_W     = $clog2(NUM_CH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*SIG_W-1:0] sample_i,
  input  logic                    cov_en,
  input  logic                    cov_clear,
  input  logic                    rd_req,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_valid,
  output logic [CNT_W-1:0]        rd_cnt,
  output logic                    rd_covered,
  output logic                    rd_err,
  output logic [COV_W-1:0]        covered_cnt,
  output logic                    all_covered
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(HIT_THRESH);

  // Number of set bits in the per-channel hit vector.
  function automatic logic [COV_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [COV_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + COV_W'(v[i]);
    end
    return n;
  endfunction

  logic [SIG_W-1:0]  last_r     [NUM_CH];
  logic [CNT_W-1:0]  cnt_r      [NUM_CH];
  logic [NUM_CH-1:0] armed_r;

  logic [SIG_W-1:0]  last_nxt_s [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt_s  [NUM_CH];
  logic [NUM_CH-1:0] armed_nxt_s;
  logic [NUM_CH-1:0] hit_s;
  logic [CNT_W-1:0]  rd_sel_s;
  logic              idx_bad_s;
  logic [COV_W-1:0]  pop_s;

  // Per-channel next state: clear beats enable; first enabled sample only arms.
  always_comb begin
    armed_nxt_s = armed_r;
    for (int c = 0; c < NUM_CH; c++) begin
      last_nxt_s[c] = last_r[c];
      cnt_nxt_s[c]  = cnt_r[c];
      if (cov_clear) begin
        cnt_nxt_s[c]   = '0;
        armed_nxt_s[c] = 1'b0;
      end else if (cov_en) begin
        if (!armed_r[c]) begin
          last_nxt_s[c]  = sample_i[c*SIG_W +: SIG_W];
          armed_nxt_s[c] = 1'b1;
        end else if (sample_i[c*SIG_W +: SIG_W] != last_r[c]) begin
          last_nxt_s[c] = sample_i[c*SIG_W +: SIG_W];
          if (cnt_r[c] != CNT_MAX) begin
            cnt_nxt_s[c] = cnt_r[c] + CNT_W'(1);
          end else begin
            cnt_nxt_s[c] = cnt_r[c];
          end
        end else begin
          last_nxt_s[c] = last_r[c];
        end
      end else begin
        cnt_nxt_s[c] = cnt_r[c];
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        last_r[c] <= '0;
        cnt_r[c]  <= '0;
      end
      armed_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        last_r[c] <= last_nxt_s[c];
        cnt_r[c]  <= cnt_nxt_s[c];
      end
      armed_r <= armed_nxt_s;
    end
  end

  // Per-channel coverage flags and read-port channel select from current counts.
  always_comb begin
    hit_s    = '0;
    rd_sel_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit_s[c] = (cnt_r[c] >= THRESH);
      if (rd_idx == IDX_W'(c)) begin
        rd_sel_s = cnt_r[c];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  assign idx_bad_s = (32'(rd_idx) >= 32'(NUM_CH));
  assign pop_s     = popcount(hit_s);

  // Read response: samples counters before this cycle's updates; holds when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_cnt     <= '0;
      rd_covered <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (idx_bad_s) begin
          rd_cnt     <= '0;
          rd_covered <= 1'b0;
          rd_err     <= 1'b1;
        end else begin
          rd_cnt     <= rd_sel_s;
          rd_covered <= (rd_sel_s >= THRESH);
          rd_err     <= 1'b0;
        end
      end else begin
        rd_cnt     <= rd_cnt;
        rd_covered <= rd_covered;
        rd_err     <= rd_err;
      end
    end
  end

  // Coverage summary, one cycle behind the counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      covered_cnt <= '0;
      all_covered <= 1'b0;
    end else begin
      covered_cnt <= pop_s;
      all_covered <= (pop_s == COV_W'(NUM_CH));
    end
  end

endmodule

// File: tb/tb_cov_toggle_collector.sv
// Directed self-checking bench for cov_toggle_collector.
// Main instance: NUM_CH=4, SIG_W=8, CNT_W=4, HIT_THRESH=2.
// A second 5-channel instance provides an out-of-range read index (5).
module tb_cov_toggle_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  samp [4];
  logic [31:0] sample_bus;
  logic        cov_en, cov_clear, rd_req;
  logic [1:0]  rd_idx;
  logic        rd_valid, rd_covered, rd_err, all_covered;
  logic [3:0]  rd_cnt;
  logic [2:0]  covered_cnt;

  logic [39:0] sample2;
  logic        rd_req2;
  logic [2:0]  rd_idx2;
  logic        rd_valid2, rd_covered2, rd_err2, all_covered2;
  logic [3:0]  rd_cnt2;
  logic [2:0]  covered_cnt2;

  int checks = 0;
  int errors = 0;

  assign sample_bus = {samp[3], samp[2], samp[1], samp[0]};

  always #5 clock = ~clock;

  cov_toggle_collector #(.NUM_CH(4), .SIG_W(8), .CNT_W(4), .HIT_THRESH(2)) u_dut (
    .clock(clock), .reset(reset), .sample_i(sample_bus), .cov_en(cov_en),
    .cov_clear(cov_clear), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_cnt(rd_cnt), .rd_covered(rd_covered),
    .rd_err(rd_err), .covered_cnt(covered_cnt), .all_covered(all_covered)
  );

  cov_toggle_collector #(.NUM_CH(5), .SIG_W(8), .CNT_W(4), .HIT_THRESH(2)) u_dut5 (
    .clock(clock), .reset(reset), .sample_i(sample2), .cov_en(1'b0),
    .cov_clear(1'b0), .rd_req(rd_req2), .rd_idx(rd_idx2),
    .rd_valid(rd_valid2), .rd_cnt(rd_cnt2), .rd_covered(rd_covered2),
    .rd_err(rd_err2), .covered_cnt(covered_cnt2), .all_covered(all_covered2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cov_en = 1'b0; cov_clear = 1'b0; rd_req = 1'b0; rd_idx = 2'd0;
    for (int i = 0; i < 4; i++) samp[i] = 8'h00;
    sample2 = 40'h0; rd_req2 = 1'b0; rd_idx2 = 3'd0;
    step(); step();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("rst_covered_cnt", 32'(covered_cnt), 32'd0);
    chk("rst_all_covered", 32'(all_covered), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    reset = 1'b0;
    step();

    // First sample is captured, not counted: 00 -> 5A -> 5A -> A5 gives 2.
    cov_en = 1'b1;
    samp[0] = 8'h00; step();
    samp[0] = 8'h5A; step();
    samp[0] = 8'h5A; step();
    samp[0] = 8'hA5; step();
    cov_en = 1'b0; rd_req = 1'b1; rd_idx = 2'd0; step();
    rd_req = 1'b0;
    chk("first_valid", 32'(rd_valid), 32'd1);
    chk("first_cnt", 32'(rd_cnt), 32'd2);
    chk("first_covered", 32'(rd_covered), 32'd1);
    chk("first_err", 32'(rd_err), 32'd0);
    chk("first_covcnt", 32'(covered_cnt), 32'd1);
    step();
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_hold_cnt", 32'(rd_cnt), 32'd2);
    chk("idle_hold_cov", 32'(rd_covered), 32'd1);

    // Saturation on ch1: 20 toggling cycles -> 15, then more toggles stay 15.
    cov_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      samp[1] = ~samp[1];
      step();
    end
    cov_en = 1'b0; rd_req = 1'b1; rd_idx = 2'd1; step();
    rd_req = 1'b0;
    chk("sat_cnt", 32'(rd_cnt), 32'd15);
    chk("sat_covcnt", 32'(covered_cnt), 32'd2);
    cov_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      samp[1] = ~samp[1];
      step();
    end
    cov_en = 1'b0; rd_req = 1'b1; rd_idx = 2'd1; step();
    rd_req = 1'b0;
    chk("sat_hold_cnt", 32'(rd_cnt), 32'd15);

    // Clear and read of ch2 in the same cycle returns the pre-clear count.
    cov_en = 1'b1;
    samp[2] = 8'h01; step();
    samp[2] = 8'h02; step();
    samp[2] = 8'h03; step();
    cov_en = 1'b0;
    cov_clear = 1'b1; rd_req = 1'b1; rd_idx = 2'd2; step();
    cov_clear = 1'b0; rd_req = 1'b0;
    chk("clr_rd_valid", 32'(rd_valid), 32'd1);
    chk("clr_rd_cnt", 32'(rd_cnt), 32'd3);
    chk("clr_rd_cov", 32'(rd_covered), 32'd1);
    step();
    rd_req = 1'b1; rd_idx = 2'd2; step();
    rd_req = 1'b0;
    chk("clr_after_cnt", 32'(rd_cnt), 32'd0);
    chk("clr_after_cov", 32'(rd_covered), 32'd0);
    cov_en = 1'b1; samp[2] = 8'h55; step();
    cov_en = 1'b0; rd_req = 1'b1; rd_idx = 2'd2; step();
    rd_req = 1'b0;
    chk("rearm_cnt", 32'(rd_cnt), 32'd0);

    // Coverage summary: ch0..ch2 twice, then ch3 twice.
    cov_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      samp[0] = samp[0] ^ 8'h01;
      samp[1] = samp[1] ^ 8'h01;
      samp[2] = samp[2] ^ 8'h01;
      step();
    end
    samp[3] = samp[3] ^ 8'h01; step();
    chk("sum_three", 32'(covered_cnt), 32'd3);
    samp[3] = samp[3] ^ 8'h01; step();
    cov_en = 1'b0;
    chk("sum_lag_cnt", 32'(covered_cnt), 32'd3);
    chk("sum_lag_all", 32'(all_covered), 32'd0);
    step();
    chk("sum_four", 32'(covered_cnt), 32'd4);
    chk("sum_all", 32'(all_covered), 32'd1);
    cov_clear = 1'b1; step();
    cov_clear = 1'b0;
    chk("sum_clr_lag", 32'(covered_cnt), 32'd4);
    step();
    chk("sum_clr_cnt", 32'(covered_cnt), 32'd0);
    chk("sum_clr_all", 32'(all_covered), 32'd0);

    // Gating: arm, count one toggle on ch3, then disabled toggles change nothing.
    cov_en = 1'b1; step();
    samp[3] = samp[3] ^ 8'h80; step();
    cov_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) samp[i] = ~samp[i];
      step();
    end
    rd_req = 1'b1; rd_idx = 2'd0; step();
    chk("gate_ch0_valid", 32'(rd_valid), 32'd1);
    chk("gate_ch0_cnt", 32'(rd_cnt), 32'd0);
    rd_idx = 2'd3; step();
    rd_req = 1'b0;
    chk("b2b_valid", 32'(rd_valid), 32'd1);
    chk("gate_ch3_cnt", 32'(rd_cnt), 32'd1);
    chk("gate_ch3_cov", 32'(rd_covered), 32'd0);
    step();
    chk("b2b_end_valid", 32'(rd_valid), 32'd0);

    // Out-of-range index on the 5-channel instance.
    rd_req2 = 1'b1; rd_idx2 = 3'd5; step();
    rd_req2 = 1'b0;
    chk("bad_valid", 32'(rd_valid2), 32'd1);
    chk("bad_err", 32'(rd_err2), 32'd1);
    chk("bad_cnt", 32'(rd_cnt2), 32'd0);
    chk("bad_cov", 32'(rd_covered2), 32'd0);
    rd_req2 = 1'b1; rd_idx2 = 3'd4; step();
    rd_req2 = 1'b0;
    chk("good_err5", 32'(rd_err2), 32'd0);

    // Reset in the same cycle as a read request drops the read.
    rd_req = 1'b1; rd_idx = 2'd3; reset = 1'b1; step();
    rd_req = 1'b0;
    chk("rr_valid", 32'(rd_valid), 32'd0);
    chk("rr_cnt", 32'(rd_cnt), 32'd0);
    chk("rr_covcnt", 32'(covered_cnt), 32'd0);
    chk("rr_all", 32'(all_covered), 32'd0);
    reset = 1'b0; step();
    chk("rr_after_valid", 32'(rd_valid), 32'd0);
    cov_en = 1'b1; samp[0] = 8'h3C; step();
    cov_en = 1'b0; rd_req = 1'b1; rd_idx = 2'd0; step();
    rd_req = 1'b0;
    chk("rr_first_cnt", 32'(rd_cnt), 32'd0);
    cov_en = 1'b1; samp[0] = 8'hC3; step();
    cov_en = 1'b0; rd_req = 1'b1; rd_idx = 2'd0; step();
    rd_req = 1'b0;
    chk("rr_count_cnt", 32'(rd_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
